// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM pipeline stage and its data RAM.
//   - mem_size_e : encoding of the mem_size port (11 behaves as a word access)
//   - state_e    : access FSM states
//   - CNT_W      : wait-state counter width (covers LATENCY up to 15)
//   - lane_mask / is_misaligned : byte-lane helpers shared by the stage
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  localparam int CNT_W = 4;

  // Little-endian byte enables for an access of the given size.
  // Half accesses look only at addr[1]; word accesses ignore the low bits.
  function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << lo;
      SIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lo[0];
      default:   mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous data RAM, DEPTH_WORDS x 32, byte-enable writes and
// a registered read port (read data appears the cycle after the address).
//   clk   : clock
//   addr  : word index
//   we    : write strobe
//   be    : per-byte write enables (bit n -> wdata[8n+7:8n])
//   wdata : write data, already placed in its byte lanes
//   rdata : registered read data of mem[addr]
// -----------------------------------------------------------------------------
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset on purpose; it maps onto RAM macros, and its
  // contents must survive a stage reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Pipeline MEM stage with a multi-cycle data memory. A request seen in IDLE is
// latched, the FSM waits LATENCY cycles in BUSY, commits the store or captures
// the extended load on the last BUSY edge, and spends one cycle in DONE.
//
// Parameters
//   DEPTH_WORDS : memory size in 32-bit words (power of two)
//   LATENCY     : wait states, 1..15
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   mem_read     : load request
//   mem_write    : store request (wins when both are high)
//   mem_size     : 00 byte, 01 half, 10/11 word
//   mem_unsigned : zero-extend loads when 1, sign-extend when 0
//   addr, wdata  : byte address, right-aligned store data
//   rdata        : registered extended load result
//   stall        : freezes the upstream pipeline while an access is in flight
//   align_err    : one-cycle misaligned-access flag (DONE cycle)
// Configuration
//   MEM_ALIGN_CHECK_EN : when defined, misaligned half/word accesses are
//   dropped and flagged on align_err; otherwise low address bits are ignored.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        align_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [AW+1:0]    addr_q;
  logic [31:0]      wdata_q;
  mem_size_e        size_q;
  logic             uns_q;
  logic             store_q;

  logic             req;
  logic             finish;
  logic             mis;
  logic [AW-1:0]    ram_addr;
  logic             ram_we;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;
  logic [31:0]      load_val;

  // Upper address bits select nothing: the memory wraps around.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign req    = mem_read | mem_write;
  assign finish = (state == ST_BUSY) && (cnt == '0);
  assign stall  = ~rst & (((state == ST_IDLE) & req) | (state == ST_BUSY));

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = is_misaligned(size_q, addr_q[1:0]);
`else
  assign mis = 1'b0;
`endif

  // In IDLE the RAM is addressed straight from the port so its registered
  // read data is already valid in the first BUSY cycle; this keeps LATENCY=1
  // working. Afterwards the latched address holds the read steady.
  assign ram_addr = (state == ST_IDLE) ? addr[AW+1:2] : addr_q[AW+1:2];
  assign ram_we   = finish & store_q & ~mis;
  assign ram_be   = lane_mask(size_q, addr_q[1:0]);

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    ram_wdata = wdata_q;
    case (size_q)
      SIZE_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      SIZE_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default:   ram_wdata = wdata_q;
    endcase
  end

  // Pick the addressed lane out of the word and extend it.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v   = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_v   = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_val = ram_rdata;
    case (size_q)
      SIZE_BYTE: load_val = {{24{~uns_q & byte_v[7]}}, byte_v};
      SIZE_HALF: load_val = {{16{~uns_q & half_v[15]}}, half_v};
      default:   load_val = ram_rdata;
    endcase
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_dmem_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is in the sensitivity list so it acts immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= SIZE_BYTE;
      uns_q     <= 1'b0;
      store_q   <= 1'b0;
      rdata     <= '0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            size_q  <= mem_size_e'(mem_size);
            uns_q   <= mem_unsigned;
            store_q <= mem_write;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!store_q && !mis) rdata <= load_val;
            align_err <= mis;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Scoreboard bench for mem_stage (DEPTH_WORDS=256, LATENCY=2). The driver
// computes each access's outcome from a word-array reference model and queues
// it; an independent monitor watches stall and, on each completed access
// (first low stall sample after a high run), checks rdata, align_err and the
// stall run length against the queue head.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int LAT        = 2;
  localparam int DEPTH      = 256;
  localparam int INIT_WORDS = 64;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, align_err;

  always #5 clk = ~clk;

  mem_stage #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .align_err    (align_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        align;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;
  int          n_vec  = 0;
  int          n_fail = 0;
  int          mon_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts stall-high samples; the first low sample after a run is
  // the DONE cycle of that access.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_run = 0;
      end else if (stall) begin
        mon_run++;
      end else if (mon_run > 0) begin
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata", rdata, e.rdata);
          check("align_err", 32'(align_err), 32'(e.align));
          check("stall_len", 32'(mon_run), 32'(LAT + 1));
        end
        mon_run = 0;
      end else begin
        check("align_err_idle", 32'(align_err), 32'd0);
      end
    end
  end

  // Reference: byte-granular word array, results from plain shift/mask rules.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          w;
    bit          mis;
    logic [31:0] v;
    w   = int'((a >> 2) % DEPTH);
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
    e.align = ALIGN_EN && mis;
    if (!e.align) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          bit         en;
          logic [7:0] d;
          case (sz)
            2'd0:    begin en = (b == int'(a[1:0])); d = wd[7:0];          end
            2'd1:    begin en = ((b / 2) == int'(a[1])); d = wd[8*(b%2) +: 8]; end
            default: begin en = 1'b1; d = wd[8*b +: 8];                     end
          endcase
          if (en) model_mem[w][8*b +: 8] = d;
        end
      end else begin
        v = model_mem[w];
        case (sz)
          2'd0: begin
            v = (v >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
          end
          2'd1: begin
            v = (v >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
          end
          default: ;
        endcase
        model_rdata = v;
      end
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    for (int i = 0; i < 40 && stall; i++) begin
      @(posedge clk); #1;
    end
    if (stall) check("access_timeout", 32'(stall), 32'd0);
  endtask

  initial begin
    logic [31:0] prior;
    rst = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    addr = '0; wdata = '0;
    model_rdata = '0;
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_align", 32'(align_err), 32'd0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill the working region so every later load has a defined value.
    for (int w = 0; w < INIT_WORDS; w++) access(1'b0, 1'b1, 2'd2, 1'b0, 32'(w) << 2, $urandom);

    // Word store then load.
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    // Sign / zero extension.
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h0000_80F0);
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h80, 32'h0);
    access(1'b1, 1'b0, 2'd0, 1'b1, 32'h80, 32'h0);
    access(1'b1, 1'b0, 2'd1, 1'b0, 32'h80, 32'h0);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h80, 32'h0);
    // Byte store into one lane.
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    access(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    // Read and write together behaves as a store; rdata holds.
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 2'd3, 1'b0, 32'h24, 32'h0);
    // Misaligned word store.
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0BAD_0BAD);
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h42, 32'h1357_9BDF);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    // Address wrap-around.
    access(1'b0, 1'b1, 2'd2, 1'b0, 32'h404, 32'h5);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h004, 32'h0);

    // Reset in the middle of a store: aborted, memory keeps its old word.
    prior = model_mem[12];
    @(posedge clk); #1;
    mem_write = 1'b1; mem_size = 2'd2; addr = 32'h30; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_write = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    model_rdata = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    check("abort_model_word", model_rdata, prior);

    // Randomised traffic over the initialised region, with random upper bits.
    for (int n = 0; n < 150; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      a  = ($urandom & ~32'h0000_03FC) | ($urandom_range(0, INIT_WORDS - 1) << 2);
      access(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
